// File: rtl/dqce_gate_ctrl.sv
// Push-button controlled CE driver for a DQCE clock gate.
// Each accepted press toggles the gated clock; completion is confirmed from a feedback toggle bit.
module dqce_gate_ctrl #(
    parameter int INV_BTN         = 0,
    parameter int DEBOUNCE_CYCLES = 270000,
    parameter int QUIET_CYCLES    = 8,
    parameter int ACK_TIMEOUT     = 64
) (
    input  logic       clk,
    input  logic       rst_i,
    input  logic       key_i,
    input  logic       gate_fb_i,
    output logic       ce_o,
    output logic       running_o,
    output logic       stopped_o,
    output logic       fault_o,
    output logic [7:0] press_cnt_o
);

    localparam int DBW = $clog2(DEBOUNCE_CYCLES);
    localparam int QW  = $clog2(QUIET_CYCLES + 1);
    localparam int TW  = $clog2(ACK_TIMEOUT + 1);

    typedef enum logic [1:0] {
        S_RUN,
        S_STOPPING,
        S_STOPPED,
        S_STARTING
    } state_t;

    // Reset asserts asynchronously but releases on a clock edge.
    logic [1:0] rst_sync_q;
    logic       rst;

    always_ff @(posedge clk or posedge rst_i) begin
        if (rst_i) rst_sync_q <= 2'b11;
        else       rst_sync_q <= {rst_sync_q[0], 1'b0};
    end

    assign rst = rst_sync_q[1];

    logic key_meta_q, key_sync_q;
    logic fb_meta_q, fb_sync_q, fb_prev_q;
    logic key_lvl, fb_act, press;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            key_meta_q <= 1'b0;
            key_sync_q <= 1'b0;
            fb_meta_q  <= 1'b0;
            fb_sync_q  <= 1'b0;
            fb_prev_q  <= 1'b0;
        end else begin
            key_meta_q <= key_i;
            key_sync_q <= key_meta_q;
            fb_meta_q  <= gate_fb_i;
            fb_sync_q  <= fb_meta_q;
            fb_prev_q  <= fb_sync_q;
        end
    end

    assign key_lvl = key_sync_q ^ 1'(INV_BTN);
    assign fb_act  = fb_sync_q != fb_prev_q;

    logic [DBW-1:0] db_cnt_q, db_cnt_d;
    logic           db_lvl_q, db_lvl_d, db_prev_q;

    always_comb begin
        db_cnt_d = '0;
        db_lvl_d = db_lvl_q;
        if (key_lvl != db_lvl_q) begin
            if (db_cnt_q == DBW'(DEBOUNCE_CYCLES - 1)) db_lvl_d = ~db_lvl_q;
            else                                       db_cnt_d = db_cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            db_cnt_q  <= '0;
            db_lvl_q  <= 1'b0;
            db_prev_q <= 1'b0;
        end else begin
            db_cnt_q  <= db_cnt_d;
            db_lvl_q  <= db_lvl_d;
            db_prev_q <= db_lvl_q;
        end
    end

    assign press = db_lvl_q & ~db_prev_q;

    state_t        state_q, state_d;
    logic [QW-1:0] quiet_q, quiet_d;
    logic [TW-1:0] timer_q, timer_d;
    logic          timed_out, accept;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_RUN;
            quiet_q <= '0;
            timer_q <= '0;
        end else begin
            state_q <= state_d;
            quiet_q <= quiet_d;
            timer_q <= timer_d;
        end
    end

    // Success is tested before the timeout, so a tie never raises a fault.
    always_comb begin
        state_d   = state_q;
        quiet_d   = '0;
        timer_d   = '0;
        timed_out = 1'b0;
        accept    = 1'b0;
        unique case (state_q)
            S_RUN: begin
                if (press) begin
                    state_d = S_STOPPING;
                    accept  = 1'b1;
                end
            end
            S_STOPPING: begin
                quiet_d = fb_act ? '0 : quiet_q + 1'b1;
                timer_d = timer_q + 1'b1;
                if (!fb_act && quiet_q == QW'(QUIET_CYCLES - 1)) begin
                    state_d = S_STOPPED;
                end else if (timer_q == TW'(ACK_TIMEOUT - 1)) begin
                    state_d   = S_STOPPED;
                    timed_out = 1'b1;
                end
            end
            S_STOPPED: begin
                if (press) begin
                    state_d = S_STARTING;
                    accept  = 1'b1;
                end
            end
            S_STARTING: begin
                timer_d = timer_q + 1'b1;
                if (fb_act) begin
                    state_d = S_RUN;
                end else if (timer_q == TW'(ACK_TIMEOUT - 1)) begin
                    state_d   = S_RUN;
                    timed_out = 1'b1;
                end
            end
            default: state_d = S_RUN;
        endcase
        if (state_d != state_q) begin
            quiet_d = '0;
            timer_d = '0;
        end
    end

    logic       ce_q, ce_d;
    logic       running_q, running_d;
    logic       stopped_q, stopped_d;
    logic       fault_q, fault_d;
    logic [7:0] cnt_q, cnt_d;

    always_comb begin
        ce_d      = (state_d == S_RUN) || (state_d == S_STARTING);
        running_d = state_d == S_RUN;
        stopped_d = state_d == S_STOPPED;
        fault_d   = fault_q | timed_out;
        cnt_d     = cnt_q + 8'(accept);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ce_q      <= 1'b1;
            running_q <= 1'b1;
            stopped_q <= 1'b0;
            fault_q   <= 1'b0;
            cnt_q     <= '0;
        end else begin
            ce_q      <= ce_d;
            running_q <= running_d;
            stopped_q <= stopped_d;
            fault_q   <= fault_d;
            cnt_q     <= cnt_d;
        end
    end

    assign ce_o        = ce_q;
    assign running_o   = running_q;
    assign stopped_o   = stopped_q;
    assign fault_o     = fault_q;
    assign press_cnt_o = cnt_q;

endmodule

// File: tb/tb_dqce_gate_ctrl.sv
// Randomised and directed bench for dqce_gate_ctrl.
// A sampled-history reference model predicts every output each cycle.
module tb_dqce_gate_ctrl;

    localparam int DB = 4;
    localparam int QC = 8;
    localparam int AT = 64;

    localparam int M_RUN      = 0;
    localparam int M_STOPPING = 1;
    localparam int M_STOPPED  = 2;
    localparam int M_STARTING = 3;

    logic       clk = 1'b0;
    logic       rst_i;
    logic       key_i;
    logic       gate_fb_i;
    logic       ce_o;
    logic       running_o;
    logic       stopped_o;
    logic       fault_o;
    logic [7:0] press_cnt_o;

    dqce_gate_ctrl #(
        .INV_BTN        (0),
        .DEBOUNCE_CYCLES(DB),
        .QUIET_CYCLES   (QC),
        .ACK_TIMEOUT    (AT)
    ) dut (
        .clk        (clk),
        .rst_i      (rst_i),
        .key_i      (key_i),
        .gate_fb_i  (gate_fb_i),
        .ce_o       (ce_o),
        .running_o  (running_o),
        .stopped_o  (stopped_o),
        .fault_o    (fault_o),
        .press_cnt_o(press_cnt_o)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // Reference model state: raw input samples per edge, debounce
    // window, and the gate phase with its age and quiet run.
    logic       mk[3];
    logic       mf[4];
    logic       win[$];
    logic       m_lvl, m_rise;
    int         m_st, m_age, m_quiet, m_acc;
    logic       m_fault;
    logic [7:0] m_cnt;

    logic ce_h1, ce_h2, fb_lvl;
    int   fb_mode;

    function automatic logic m_ce();
        return (m_st == M_RUN) || (m_st == M_STARTING);
    endfunction

    function automatic void mdl_reset();
        for (int i = 0; i < 3; i++) mk[i] = 1'b0;
        for (int i = 0; i < 4; i++) mf[i] = 1'b0;
        win.delete();
        m_lvl   = 1'b0;
        m_rise  = 1'b0;
        m_st    = M_RUN;
        m_age   = 0;
        m_quiet = 0;
        m_acc   = 0;
        m_fault = 1'b0;
        m_cnt   = 8'd0;
        ce_h1   = 1'b1;
        ce_h2   = 1'b1;
    endfunction

    function automatic void enter(input int st);
        m_st    = st;
        m_age   = 0;
        m_quiet = 0;
    endfunction

    // The logic sees a raw input two edges after it was sampled.
    function automatic void mdl_step(input logic k, input logic f);
        logic act, press, flip;
        mk[2] = mk[1]; mk[1] = mk[0]; mk[0] = k;
        mf[3] = mf[2]; mf[2] = mf[1]; mf[1] = mf[0]; mf[0] = f;
        act   = mf[2] != mf[3];
        press = m_rise;
        case (m_st)
            M_RUN: if (press) begin
                enter(M_STOPPING); m_cnt++; m_acc++;
            end
            M_STOPPING: begin
                m_age++;
                m_quiet = act ? 0 : m_quiet + 1;
                if (m_quiet >= QC) enter(M_STOPPED);
                else if (m_age >= AT) begin
                    enter(M_STOPPED); m_fault = 1'b1;
                end
            end
            M_STOPPED: if (press) begin
                enter(M_STARTING); m_cnt++; m_acc++;
            end
            default: begin
                m_age++;
                if (act) enter(M_RUN);
                else if (m_age >= AT) begin
                    enter(M_RUN); m_fault = 1'b1;
                end
            end
        endcase
        win.push_back(mk[2]);
        if (win.size() > DB) void'(win.pop_front());
        flip = win.size() == DB;
        foreach (win[i]) if (win[i] == m_lvl) flip = 1'b0;
        m_rise = flip && !m_lvl;
        if (flip) m_lvl = ~m_lvl;
    endfunction

    task automatic check_all();
        check("ce", ce_o, m_ce());
        check("running", running_o, m_st == M_RUN);
        check("stopped", stopped_o, m_st == M_STOPPED);
        check("fault", fault_o, m_fault);
        check("press_cnt", press_cnt_o, m_cnt);
    endtask

    task automatic cyc(input logic k, input logic f);
        key_i     = k;
        gate_fb_i = f;
        @(posedge clk);
        mdl_step(k, f);
        ce_h2 = ce_h1;
        ce_h1 = m_ce();
        @(negedge clk);
        check_all();
    endtask

    // fb_mode: 0 idle, 1 always toggling, 2 follows CE, 3 follows CE with gaps
    task automatic cyc_m(input logic k);
        case (fb_mode)
            1:       fb_lvl = ~fb_lvl;
            2:       if (ce_h2) fb_lvl = ~fb_lvl;
            3:       if (ce_h2 && $urandom_range(0, 7) != 0) fb_lvl = ~fb_lvl;
            default: fb_lvl = fb_lvl;
        endcase
        cyc(k, fb_lvl);
    endtask

    task automatic do_reset();
        rst_i     = 1'b1;
        key_i     = 1'b0;
        gate_fb_i = 1'b0;
        fb_lvl    = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_ce", ce_o, 1);
        check("rst_running", running_o, 1);
        check("rst_stopped", stopped_o, 0);
        check("rst_fault", fault_o, 0);
        check("rst_cnt", press_cnt_o, 0);
        rst_i = 1'b0;
        repeat (3) @(negedge clk);
        check("rel_ce", ce_o, 1);
        check("rel_cnt", press_cnt_o, 0);
        mdl_reset();
    endtask

    int fall_i, stop_i, rise_i, run_i, tog_i, budget;
    logic k;

    initial begin
        rst_i = 1'b1; key_i = 1'b0; gate_fb_i = 1'b0;
        fb_lvl = 1'b0; fb_mode = 0;
        @(negedge clk);
        do_reset();

        // idle with a toggling gated clock
        fb_mode = 1;
        repeat (100) cyc_m(1'b0);
        check("t1_ce", ce_o, 1);
        check("t1_cnt", press_cnt_o, 0);

        // 3-cycle glitch is one short of the debounce window
        repeat (3) cyc_m(1'b1);
        repeat (12) cyc_m(1'b0);
        check("t2_running", running_o, 1);
        check("t2_cnt", press_cnt_o, 0);

        // stop: fb keeps toggling 2 cycles past the CE fall
        fall_i = -1; stop_i = -1;
        for (int i = 0; i < 40; i++) begin
            if (fall_i < 0 || i <= fall_i + 2) fb_lvl = ~fb_lvl;
            cyc(i < 10, fb_lvl);
            if (fall_i < 0 && ce_o === 1'b0) fall_i = i;
            if (stop_i < 0 && stopped_o === 1'b1) stop_i = i;
        end
        check("t3_fall_edge", fall_i, 6);
        check("t3_stop_edge", stop_i, 18);
        check("t3_cnt", press_cnt_o, 1);
        check("t3_fault", fault_o, 0);

        // start: fb resumes 5 cycles after CE rises
        rise_i = -1; run_i = -1; tog_i = -1;
        for (int i = 0; i < 40; i++) begin
            if (rise_i >= 0 && i >= rise_i + 5) begin
                fb_lvl = ~fb_lvl;
                if (tog_i < 0) tog_i = i;
            end
            cyc(i < 8, fb_lvl);
            if (rise_i < 0 && ce_o === 1'b1) rise_i = i;
            if (run_i < 0 && running_o === 1'b1) run_i = i;
        end
        check("t4_rise_edge", rise_i, 6);
        check("t4_run_edge", run_i, 13);
        check("t4_run_within_4", (run_i - tog_i) <= 4, 1);
        check("t4_cnt", press_cnt_o, 2);

        // stop never acknowledged: times out into STOPPED
        fb_mode = 1; stop_i = -1;
        for (int i = 0; i < 90; i++) begin
            cyc_m(i < 8);
            if (stop_i < 0 && stopped_o === 1'b1) stop_i = i;
        end
        check("t5_timeout_edge", stop_i, 70);
        check("t5_fault", fault_o, 1);
        fb_mode = 2;
        repeat (8) cyc_m(1'b1);
        repeat (30) cyc_m(1'b0);
        check("t5_running", running_o, 1);
        check("t5_fault_sticky", fault_o, 1);
        check("t5_cnt", press_cnt_o, 4);

        // second press lands inside STOPPING and is dropped
        fb_mode = 1;
        for (int i = 0; i < 92; i++) cyc_m(i < 8 || (i >= 16 && i < 24));
        check("t6_dropped_cnt", press_cnt_o, 5);
        check("t6_stopped", stopped_o, 1);
        fb_mode = 0;
        repeat (8) cyc_m(1'b1);
        repeat (4) cyc_m(1'b0);
        check("t6_starting", running_o, 0);
        rst_i = 1'b1;
        #1;
        check("t6_async_ce", ce_o, 1);
        check("t6_async_cnt", press_cnt_o, 0);
        check("t6_async_fault", fault_o, 0);
        do_reset();

        // 256 accepted presses wrap the counter
        fb_mode = 2; budget = 0;
        while (m_acc < 256 && budget < 20000) begin
            cyc_m((budget % 24) < 8);
            budget++;
        end
        check("wrap_presses", m_acc, 256);
        check("wrap_cnt", press_cnt_o, 0);

        // random holds and feedback behaviour
        for (int s = 0; s < 300; s++) begin
            k = 1'($urandom_range(0, 1));
            fb_mode = $urandom_range(0, 3);
            repeat ($urandom_range(1, 12)) cyc_m(k);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_bad);
        $finish;
    end

endmodule
